trace_lockstep_cmp: RTL and testbench

Lockstep trace checker for dual-core equivalence runs. It consumes the `trace_valid`/`trace_data` streams of two picorv32 instances and buffers each stream in its own FIFO, so the cores may drift apart by up to `DEPTH` entries. It compares the buffered words pairwise in retirement order and latches the first divergence or buffer overflow as a sticky failure, for use in formal or simulation harnesses.

---
 rtl/trace_lockstep_cmp.sv | 172 +++++++++++++++++
 tb/tb_trace_lockstep_cmp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_lockstep_cmp.sv
// Lockstep trace checker: buffers two retirement trace streams in per-core
// FIFOs, compares the heads pairwise and latches the first divergence or
// overflow as a sticky failure.

// Single trace FIFO. Occupancy is tracked by a count so full/empty never
// depend on pointer equality; pointers simply wrap.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 36,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

module trace_lockstep_cmp #(
    parameter int          DEPTH    = 16,
    parameter logic [35:0] CMP_MASK = 36'hF_FFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_valid_0,
    input  logic [35:0]              trace_data_0,
    input  logic                     trace_valid_1,
    input  logic [35:0]              trace_data_1,
    output logic [$clog2(DEPTH):0]   level_0,
    output logic [$clog2(DEPTH):0]   level_1,
    output logic [31:0]              match_count,
    output logic                     mismatch,
    output logic                     overflow,
    output logic [35:0]              fail_data_0,
    output logic [35:0]              fail_data_1,
    output logic                     idle
);
    localparam int NUM_CORES = 2;
    localparam int LW        = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, FAIL} state_t;

    state_t                          state, state_nx;
    logic [NUM_CORES-1:0]            tv;
    logic [NUM_CORES-1:0][35:0]      td;
    logic [NUM_CORES-1:0][35:0]      head;
    logic [NUM_CORES-1:0][LW-1:0]    lvl;
    logic [NUM_CORES-1:0]            push;
    logic [NUM_CORES-1:0]            drop;
    logic                            pop;
    logic                            cmp_vld;
    logic                            cmp_diff;
    logic [35:0]                     cmp_a;
    logic [35:0]                     cmp_b;

    assign tv = {trace_valid_1, trace_valid_0};
    assign td = {trace_data_1, trace_data_0};

    assign cmp_diff = ((cmp_a ^ cmp_b) & CMP_MASK) != '0;

    // Next state plus push/pop decisions; nothing moves once in FAIL.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        push     = '0;
        drop     = '0;
        case (state)
            RUN: begin
                pop = (lvl[0] != '0) && (lvl[1] != '0);
                for (int k = 0; k < NUM_CORES; k++) begin
                    // A same-cycle pop frees the slot the push needs.
                    push[k] = tv[k] && ((lvl[k] != LW'(DEPTH)) || pop);
                    drop[k] = tv[k] && (lvl[k] == LW'(DEPTH)) && !pop;
                end
                if ((|drop) || (cmp_vld && cmp_diff)) state_nx = FAIL;
            end
            FAIL: begin
                state_nx = FAIL;
            end
            default: state_nx = RUN;
        endcase
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_fifo
        trace_fifo #(.DEPTH(DEPTH), .W(36), .LW(LW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .pop   (pop),
            .wdata (td[k]),
            .rdata (head[k]),
            .level (lvl[k])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // Compare stage: capture both heads when a pair is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_vld <= 1'b0;
            cmp_a   <= '0;
            cmp_b   <= '0;
        end else if (state == RUN) begin
            cmp_vld <= pop;
            if (pop) begin
                cmp_a <= head[0];
                cmp_b <= head[1];
            end
        end else begin
            cmp_vld <= 1'b0;
        end
    end

    // Sticky result flags and match counter; frozen outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
            mismatch    <= 1'b0;
            overflow    <= 1'b0;
            fail_data_0 <= '0;
            fail_data_1 <= '0;
        end else if (state == RUN) begin
            if (|drop) overflow <= 1'b1;
            if (cmp_vld) begin
                if (cmp_diff) begin
                    mismatch    <= 1'b1;
                    fail_data_0 <= cmp_a;
                    fail_data_1 <= cmp_b;
                end else begin
                    match_count <= match_count + 32'd1;
                end
            end
        end
    end

    assign level_0 = lvl[0];
    assign level_1 = lvl[1];
    assign idle    = (lvl[0] == '0) && (lvl[1] == '0) && !cmp_vld;
endmodule

// File: tb/tb_trace_lockstep_cmp.sv
// Randomized and directed bench for trace_lockstep_cmp against a queue-based
// reference model of the two trace streams.
module tb_trace_lockstep_cmp;
    localparam int          DEPTH = 16;
    localparam logic [35:0] MASK  = 36'h7_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_valid_0 = 1'b0, trace_valid_1 = 1'b0;
    logic [35:0] trace_data_0 = '0, trace_data_1 = '0;
    logic [4:0]  level_0, level_1;
    logic [31:0] match_count;
    logic        mismatch, overflow, idle;
    logic [35:0] fail_data_0, fail_data_1;

    trace_lockstep_cmp #(.DEPTH(DEPTH), .CMP_MASK(MASK)) dut (
        .clk(clk), .reset(reset),
        .trace_valid_0(trace_valid_0), .trace_data_0(trace_data_0),
        .trace_valid_1(trace_valid_1), .trace_data_1(trace_data_1),
        .level_0(level_0), .level_1(level_1), .match_count(match_count),
        .mismatch(mismatch), .overflow(overflow),
        .fail_data_0(fail_data_0), .fail_data_1(fail_data_1), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each core's buffer is a queue, one pending compare.
    logic [35:0] q0[$], q1[$];
    bit          m_cv, m_failed, m_mm, m_ov;
    logic [35:0] m_a, m_b, m_fd0, m_fd1;
    int unsigned m_mc;
    int          peak_obs, peak_mdl;

    task automatic model_edge(input bit rst, input bit v0, input logic [35:0] d0,
                              input bit v1, input logic [35:0] d1);
        bit go_fail;
        if (rst) begin
            q0.delete(); q1.delete();
            m_cv = 0; m_failed = 0; m_mm = 0; m_ov = 0;
            m_a = '0; m_b = '0; m_fd0 = '0; m_fd1 = '0; m_mc = 0;
            return;
        end
        if (m_failed) begin
            m_cv = 0;
            return;
        end
        go_fail = 0;
        if (m_cv) begin
            if (((m_a ^ m_b) & MASK) != 0) begin
                m_mm = 1; m_fd0 = m_a; m_fd1 = m_b; go_fail = 1;
            end else begin
                m_mc++;
            end
        end
        if (q0.size() > 0 && q1.size() > 0) begin
            m_a = q0.pop_front(); m_b = q1.pop_front(); m_cv = 1;
        end else begin
            m_cv = 0;
        end
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else begin m_ov = 1; go_fail = 1; end
        end
        if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else begin m_ov = 1; go_fail = 1; end
        end
        m_failed = go_fail;
    endtask

    // One clock: drive inputs, advance the model at the edge, check all outputs.
    task automatic step(input bit rst, input bit v0, input logic [35:0] d0,
                        input bit v1, input logic [35:0] d1);
        reset = rst; trace_valid_0 = v0; trace_data_0 = d0;
        trace_valid_1 = v1; trace_data_1 = d1;
        @(posedge clk);
        model_edge(rst, v0, d0, v1, d1);
        #1;
        chk("level_0", 64'(level_0), 64'(q0.size()));
        chk("level_1", 64'(level_1), 64'(q1.size()));
        chk("match_count", 64'(match_count), 64'(m_mc));
        chk("mismatch", 64'(mismatch), 64'(m_mm));
        chk("overflow", 64'(overflow), 64'(m_ov));
        chk("fail_data_0", 64'(fail_data_0), 64'(m_fd0));
        chk("fail_data_1", 64'(fail_data_1), 64'(m_fd1));
        chk("idle", 64'(idle), 64'(q0.size() == 0 && q1.size() == 0 && !m_cv));
        if (int'(level_0) > peak_obs) peak_obs = int'(level_0);
        if (q0.size() > peak_mdl) peak_mdl = q0.size();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, '0);
    endtask

    function automatic logic [35:0] rword();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    logic [35:0] w [0:399];

    // Random independent valids on identical streams, optional corrupted index.
    task automatic random_run(input int cycles, input int bad_idx);
        int i0, i1;
        bit v0, v1;
        logic [35:0] d1;
        for (int i = 0; i < 400; i++) w[i] = rword();
        i0 = 0; i1 = 0;
        for (int c = 0; c < cycles; c++) begin
            v0 = ($urandom_range(0, 99) < 60) && i0 < 400;
            v1 = ($urandom_range(0, 99) < 60) && i1 < 400;
            d1 = v1 ? w[i1] : '0;
            if (v1 && i1 == bad_idx) d1 = d1 ^ 36'h1;
            step(0, v0, v0 ? w[i0] : '0, v1, d1);
            if (v0) i0++;
            if (v1) i1++;
        end
    endtask

    initial begin
        logic [35:0] d;
        peak_obs = 0; peak_mdl = 0;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_mc", 64'(match_count), 64'd0);
        chk("rst_lvl0", 64'(level_0), 64'd0);

        // Identical 100-word streams, same cycles
        for (int i = 0; i < 100; i++) begin
            d = rword();
            step(0, 1, d, 1, d);
            chk("eqrate_lvl0", 64'(level_0), 64'd1);
        end
        idle_cycles(3);
        chk("s1_mc", 64'(match_count), 64'd100);
        chk("s1_mm", 64'(mismatch), 64'd0);
        chk("s1_ov", 64'(overflow), 64'd0);
        chk("s1_idle", 64'(idle), 64'd1);

        // Core 1 delayed by 10 cycles
        do_reset();
        peak_obs = 0; peak_mdl = 0;
        for (int i = 0; i < 20; i++) w[i] = rword();
        for (int c = 0; c < 30; c++) begin
            if (c == 10) chk("lead10_lvl0", 64'(level_0), 64'd10);
            step(0, c < 20, c < 20 ? w[c] : '0, c >= 10, c >= 10 ? w[c-10] : '0);
        end
        idle_cycles(4);
        chk("s2_peak", 64'(peak_obs), 64'(peak_mdl));
        chk("s2_mc", 64'(match_count), 64'd20);
        chk("s2_flags", 64'({mismatch, overflow}), 64'd0);

        // Word index 3 differs
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = rword();
            if (i == 3) step(0, 1, 36'h5, 1, 36'h7);
            else        step(0, 1, d, 1, d);
        end
        idle_cycles(3);
        chk("s3_mm", 64'(mismatch), 64'd1);
        chk("s3_fd0", 64'(fail_data_0), 64'h5);
        chk("s3_fd1", 64'(fail_data_1), 64'h7);
        chk("s3_mc", 64'(match_count), 64'd3);
        random_run(20, -1);
        chk("s3_frozen_mc", 64'(match_count), 64'd3);
        chk("s3_frozen_fd0", 64'(fail_data_0), 64'h5);

        // 17 words into core 0, core 1 silent
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1, rword(), 0, '0);
        chk("s4_ov_before", 64'(overflow), 64'd0);
        step(0, 1, rword(), 0, '0);
        chk("s4_ov", 64'(overflow), 64'd1);
        chk("s4_lvl0", 64'(level_0), 64'd16);
        idle_cycles(2);

        // Full FIFO accepts a push in a pop cycle
        do_reset();
        for (int i = 0; i < 16; i++) w[i] = rword();
        for (int i = 0; i < 16; i++) step(0, 1, w[i], 0, '0);
        step(0, 0, '0, 1, w[0]);
        step(0, 1, rword(), 0, '0);
        chk("s5_ov", 64'(overflow), 64'd0);
        chk("s5_lvl0", 64'(level_0), 64'd16);
        idle_cycles(3);
        chk("s5_mc", 64'(match_count), 64'd1);

        // Bit 35 is masked out
        do_reset();
        d = rword();
        step(0, 1, d & 36'h7_FFFF_FFFF, 1, d | 36'h8_0000_0000);
        idle_cycles(3);
        chk("s6_mc", 64'(match_count), 64'd1);
        chk("s6_mm", 64'(mismatch), 64'd0);

        // Reset mid-run with level_0=5 and mismatch=1
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 36'h10 + 36'(i), 0, '0);
        step(0, 0, '0, 1, 36'h99);
        step(0, 1, 36'h20, 0, '0);
        idle_cycles(2);
        chk("s7_mm", 64'(mismatch), 64'd1);
        chk("s7_lvl0", 64'(level_0), 64'd5);
        do_reset();
        chk("s7_rst_lvl0", 64'(level_0), 64'd0);
        chk("s7_rst_mm", 64'(mismatch), 64'd0);
        chk("s7_rst_fd0", 64'(fail_data_0), 64'd0);
        chk("s7_rst_idle", 64'(idle), 64'd1);
        for (int i = 0; i < 20; i++) begin
            d = rword();
            step(0, 1, d, 1, d);
        end
        idle_cycles(3);
        chk("s7_mc", 64'(match_count), 64'd20);
        chk("s7_mm_after", 64'(mismatch), 64'd0);

        // Randomized traffic, clean then with one corrupted word
        do_reset();
        random_run(400, -1);
        idle_cycles(20);
        do_reset();
        random_run(300, 40);
        idle_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
